pcs_tx_gearbox_66b: RTL and testbench
=====================================

Name: pcs_tx_gearbox_66b

Overview:
Parametrised 64b/66b synchronous TX gearbox for DATA_WIDTH of 32 or 64.
- Sits between the scrambler and the GTY transceiver TX data port.
- Packs 66-bit blocks (sync header plus scrambled payload) into a continuous DATA_WIDTH-bit line stream.
- Uses a 33-state sequence counter and drives the pause back-pressure to the encoder.
- Over the previous gearbox it adds a 64-bit datapath, underflow detection/substitution, a sequence-counter status output and a stall-free bypass mode.

Parameters:
DATA_WIDTH, 32, line/payload word width; legal values 32 or 64, anything else is a $fatal at elaboration.
HDR_WIDTH, 2, sync header width; fixed at 2.
SEQ_MAX, 32, last sequence count; the sequence period is SEQ_MAX+1 = 33 cycles.

Ports:
i_clk  in  1  GTY TX user clock (txusrclk2); sole clock.
i_reset_n  in  1  asynchronous active-low reset.
i_data  in  DATA_WIDTH  scrambled payload word; for DATA_WIDTH=32, one half of a 64-bit payload.
i_data_valid  in  1  i_data/i_hdr valid this cycle.
i_hdr  in  HDR_WIDTH  sync header; sampled only on the first word of a block.
i_bypass  in  1  quasi-static; 1 = pass i_data straight through with no header, pause never asserted.
o_data  out  DATA_WIDTH  line word to transceiver; bit 0 transmitted first.
o_gearbox_pause  out  1  upstream must not present data this cycle.
o_seq  out  6  current sequence count, 0..SEQ_MAX.
o_underflow  out  1  sticky; set on any non-pause cycle with i_data_valid=0 (gearbox mode only).

Behaviour:
Reset (async assert, sync deassert internally):
- o_data=0, o_gearbox_pause=0, o_seq=0, o_underflow=0.
- Buffer occupancy=0; half toggle=0 (expecting first half).

Sequence counter:
- Increments each cycle in gearbox mode; wraps SEQ_MAX->0.
- o_gearbox_pause = (seq==SEQ_MAX) && !i_bypass, decoded from the registered seq, so it is valid in the same cycle.
- When pause is high, i_data, i_hdr and i_data_valid are ignored and nothing is appended.

Append rule on each non-pause cycle:
- DATA_WIDTH=64: append {i_data, i_hdr} = 66 bits, header in LSBs.
- DATA_WIDTH=32: if half toggle=0, append {i_data, i_hdr} = 34 bits; else append i_data = 32 bits. Half toggle flips.

Output rule, every cycle:
- o_data <= low DATA_WIDTH bits of (buffer | appended bits << occupancy).
- Occupancy becomes occupancy + appended - DATA_WIDTH.
- Latency: 1 cycle from input to the first output bit.

Occupancy bounds:
- Grows by 2 bits per 66-bit block, so it reaches DATA_WIDTH at seq SEQ_MAX. The pause cycle drains it to 0, aligned with seq=0.
- Buffer width 2*DATA_WIDTH+HDR_WIDTH. Occupancy must never exceed this; an SVA checks it and checks occupancy==0 whenever seq==0.

Underflow (non-pause cycle, i_data_valid=0):
- Substitute payload 0 and header 2'b00 (invalid header, so the far-end block lock counts an error).
- Half toggle and sequence advance normally; alignment is never lost.
- o_underflow set; cleared only by reset.

Bypass (i_bypass=1):
- o_data <= i_data; seq held at 0; pause 0; buffer flushed to 0; half toggle reset.
- Toggling i_bypass mid-sequence is legal: the counter restarts at seq=0 on return to gearbox mode and the first word is treated as a header-bearing half.

Decomposition:
Shared package pcs_pkg holds:
- SYNC_HDR_DATA=2'b01, SYNC_HDR_CTRL=2'b10, SYNC_HDR_INVALID=2'b00.
- GB_SEQ_MAX=32.
- typedef gb_seq_t (logic [5:0]).

No sub-module; the counter and shift buffer stay in one module. The pcs top instantiates it in place of the old gearbox.

Test Plan:
1. DW=32: reset, stream 16 blocks of hdr 01 / payload 0xA5A5A5A5_5A5A5A5A -> pause high exactly at seq 32; reassembled line bits match the reference 66b stream bit-exactly; occupancy 0 at seq 0.
2. DW=64: 64 blocks alternating hdr 01/10, incrementing payload -> pause one cycle in 33; de-gearboxed output equals input blocks; no underflow.
3. Drop i_data_valid at seq 5 for one cycle -> o_underflow=1 and stays set; one block decodes with hdr 00; the following blocks stay aligned.
4. Drive i_data=0xDEADBEEF with i_data_valid=1 during the pause cycle -> value absent from the output stream.
5. Assert i_reset_n=0 at seq 17 mid-stream -> all outputs 0 asynchronously; after release seq restarts at 0, and the first output word carries the header of the first new block in bits [1:0].
6. i_bypass=1 with words 0x1,0x2,0x3 -> o_data = 0x1,0x2,0x3 one cycle later, pause never asserted; drop bypass -> seq counts from 0.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared PCS definitions: 64b/66b sync header codes and gearbox sequence type.
package pcs_pkg;

  localparam logic [1:0] SYNC_HDR_DATA    = 2'b01;
  localparam logic [1:0] SYNC_HDR_CTRL    = 2'b10;
  localparam logic [1:0] SYNC_HDR_INVALID = 2'b00;

  localparam int GB_SEQ_MAX = 32;

  typedef logic [5:0] gb_seq_t;

endpackage

// File: rtl/pcs_tx_gearbox_66b.sv
// 64b/66b TX gearbox: packs 66-bit blocks (header in LSBs) into a continuous
// DATA_WIDTH-bit line stream for the transceiver, bit 0 transmitted first.
//
// Flow control: o_gearbox_pause is decoded from the registered sequence count
// and is valid in the same cycle. While it is high the upstream word is
// ignored (nothing appended); on every other gearbox-mode cycle the upstream
// must present a word, and a missing one (i_data_valid=0) is replaced by a
// zero payload with an invalid header and latched in o_underflow.
module pcs_tx_gearbox_66b
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2,
  parameter int SEQ_MAX    = GB_SEQ_MAX
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic [HDR_WIDTH-1:0]  i_hdr,
  input  logic                  i_bypass,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_gearbox_pause,
  output gb_seq_t               o_seq,
  output logic                  o_underflow
);

  // Buffer holds up to one line word of carry plus a full appended block.
  localparam int BUF_W = 2 * DATA_WIDTH + HDR_WIDTH;
  localparam int OCC_W = 8;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $fatal(1, "pcs_tx_gearbox_66b: DATA_WIDTH must be 32 or 64");
  end
  if (HDR_WIDTH != 2) begin : g_bad_hdr
    $fatal(1, "pcs_tx_gearbox_66b: HDR_WIDTH must be 2");
  end

  logic [1:0]            rst_sync_q;
  logic                  rst_int_n;
  gb_seq_t               seq_q, seq_d;
  logic                  half_q, half_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  underflow_q, underflow_d;

  logic                  pause;
  logic [DATA_WIDTH-1:0] payload;
  logic [HDR_WIDTH-1:0]  hdr;
  logic [BUF_W-1:0]      app_bits;
  logic [OCC_W-1:0]      app_len;
  logic [BUF_W-1:0]      combined;

  // Reset synchroniser: asserts immediately, releases two clocks after i_reset_n.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  assign pause = (seq_q == gb_seq_t'(SEQ_MAX)) && !i_bypass;

  // Next-state: sequence count, half toggle, append/shift of the line buffer.
  always_comb begin
    seq_d       = seq_q;
    half_d      = half_q;
    occ_d       = occ_q;
    buf_d       = buf_q;
    data_d      = data_q;
    underflow_d = underflow_q;
    payload     = '0;
    hdr         = '0;
    app_bits    = '0;
    app_len     = '0;
    combined    = '0;
    if (i_bypass) begin
      data_d = i_data;
      seq_d  = '0;
      half_d = 1'b0;
      occ_d  = '0;
      buf_d  = '0;
    end else begin
      seq_d = (seq_q == gb_seq_t'(SEQ_MAX)) ? '0 : seq_q + gb_seq_t'(1);
      if (!pause) begin
        payload = i_data_valid ? i_data : '0;
        hdr     = i_data_valid ? i_hdr : HDR_WIDTH'(SYNC_HDR_INVALID);
        if (!i_data_valid) underflow_d = 1'b1;
        // 64-bit words always start a block; 32-bit words alternate halves.
        if (DATA_WIDTH == 64 || !half_q) begin
          app_bits = BUF_W'({payload, hdr});
          app_len  = OCC_W'(DATA_WIDTH + HDR_WIDTH);
        end else begin
          app_bits = BUF_W'(payload);
          app_len  = OCC_W'(DATA_WIDTH);
        end
        if (DATA_WIDTH == 32) half_d = ~half_q;
      end
      // The pause cycle appends nothing and drains the accumulated carry.
      combined = buf_q | (app_bits << occ_q);
      data_d   = combined[DATA_WIDTH-1:0];
      buf_d    = combined >> DATA_WIDTH;
      occ_d    = occ_q + app_len - OCC_W'(DATA_WIDTH);
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      seq_q       <= '0;
      half_q      <= 1'b0;
      occ_q       <= '0;
      buf_q       <= '0;
      data_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      seq_q       <= seq_d;
      half_q      <= half_d;
      occ_q       <= occ_d;
      buf_q       <= buf_d;
      data_q      <= data_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_data          = data_q;
  assign o_gearbox_pause = pause;
  assign o_seq           = seq_q;
  assign o_underflow     = underflow_q;

  a_occ_bound: assert property (@(posedge i_clk) disable iff (!rst_int_n)
    int'(occ_q) <= BUF_W);
  a_occ_aligned: assert property (@(posedge i_clk) disable iff (!rst_int_n)
    (seq_q == '0) |-> (occ_q == '0));

endmodule

// File: tb/tb_pcs_tx_gearbox_66b.sv
// Bench for pcs_tx_gearbox_66b: one 32-bit and one 64-bit instance, driven one
// at a time. The reference is the serial 66b block stream; expected line words
// are cut from it and queued, then popped when the DUT emits them.
module tb_pcs_tx_gearbox_66b;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [31:0] a_data;
  logic        a_valid;
  logic [1:0]  a_hdr;
  logic        a_byp;
  logic [31:0] a_odata;
  logic        a_pause;
  logic [5:0]  a_seq;
  logic        a_uf;

  logic [63:0] b_data;
  logic        b_valid;
  logic [1:0]  b_hdr;
  logic        b_byp;
  logic [63:0] b_odata;
  logic        b_pause;
  logic [5:0]  b_seq;
  logic        b_uf;

  pcs_tx_gearbox_66b #(.DATA_WIDTH(32)) dut32 (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(a_data), .i_data_valid(a_valid),
    .i_hdr(a_hdr), .i_bypass(a_byp), .o_data(a_odata), .o_gearbox_pause(a_pause),
    .o_seq(a_seq), .o_underflow(a_uf)
  );

  pcs_tx_gearbox_66b #(.DATA_WIDTH(64)) dut64 (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(b_data), .i_data_valid(b_valid),
    .i_hdr(b_hdr), .i_bypass(b_byp), .o_data(b_odata), .o_gearbox_pause(b_pause),
    .o_seq(b_seq), .o_underflow(b_uf)
  );

  // ---------------- scoreboard state ----------------
  int          w;
  bit          stream_q[$];
  logic [63:0] exp_q[$];
  int          exp_seq;
  bit          half;
  bit          exp_uf;
  int          total;
  int          bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_width(input int n);
    w = n;
    if (n == 32) begin
      b_byp = 1'b1; b_valid = 1'b0; b_data = '0; b_hdr = '0;
    end else begin
      a_byp = 1'b1; a_valid = 1'b0; a_data = '0; a_hdr = '0;
    end
  endtask

  task automatic drive_in(input logic [63:0] d, input logic [1:0] h, input logic v,
                          input logic byp);
    if (w == 32) begin
      a_data = d[31:0]; a_hdr = h; a_valid = v; a_byp = byp;
    end else begin
      b_data = d; b_hdr = h; b_valid = v; b_byp = byp;
    end
  endtask

  task automatic sample(output logic [63:0] od, output logic op, output logic [5:0] os,
                        output logic ou);
    if (w == 32) begin
      od = {32'h0, a_odata}; op = a_pause; os = a_seq; ou = a_uf;
    end else begin
      od = b_odata; op = b_pause; os = b_seq; ou = b_uf;
    end
  endtask

  task automatic check_out();
    logic [63:0] od;
    logic        op, ou;
    logic [5:0]  os;
    sample(od, op, os, ou);
    check("seq", 64'(os), 64'(exp_seq));
    check("pause", 64'(op), 64'(exp_seq == 32));
    check("underflow", 64'(ou), 64'(exp_uf));
    if (exp_q.size() > 0) check("line_word", od, exp_q.pop_front());
  endtask

  // One gearbox-mode cycle; called at a negedge, returns at the next negedge.
  task automatic tick(input logic [63:0] d, input logic [1:0] h, input logic v);
    logic [63:0] dd, wd;
    logic [1:0]  hh;
    check_out();
    drive_in(d, h, v, 1'b0);
    if (exp_seq != 32) begin
      dd = v ? d : 64'h0;
      hh = v ? h : 2'b00;
      if (!v) exp_uf = 1'b1;
      if (w == 64 || !half)
        for (int i = 0; i < 2; i++) stream_q.push_back(hh[i]);
      for (int i = 0; i < w; i++) stream_q.push_back(dd[i]);
      if (w == 32) half = ~half;
    end
    wd = '0;
    for (int i = 0; i < w; i++) wd[i] = (stream_q.size() > 0) ? stream_q.pop_front() : 1'b0;
    exp_q.push_back(wd);
    exp_seq = (exp_seq == 32) ? 0 : exp_seq + 1;
    @(negedge clk);
  endtask

  // On the pause slot, offer a marker word that must never reach the line.
  task automatic pause_if_needed();
    if (exp_seq == 32) tick(64'hDEADBEEF_DEADBEEF, 2'b11, 1'b1);
  endtask

  task automatic send_block(input logic [1:0] h, input logic [63:0] p, input logic v);
    if (w == 64) begin
      pause_if_needed();
      tick(p, h, v);
    end else begin
      pause_if_needed();
      tick({32'h0, p[31:0]}, h, v);
      pause_if_needed();
      tick({32'h0, p[63:32]}, h, v);
    end
  endtask

  task automatic reset_dut();
    logic [63:0] od;
    logic        op, ou;
    logic [5:0]  os;
    rst_n = 1'b0;
    drive_in(64'h0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    sample(od, op, os, ou);
    check("rst_data", od, 64'h0);
    check("rst_pause", 64'(op), 64'h0);
    check("rst_seq", 64'(os), 64'h0);
    check("rst_uf", 64'(ou), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stream_q.delete();
    exp_q.delete();
    exp_seq = 0;
    half    = 1'b0;
    exp_uf  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] od;
    logic        op, ou;
    logic [5:0]  os;
    total = 0; bad = 0;
    rst_n = 1'b0;
    a_data = '0; a_valid = 1'b0; a_hdr = '0; a_byp = 1'b0;
    b_data = '0; b_valid = 1'b0; b_hdr = '0; b_byp = 1'b0;
    stream_q.delete(); exp_q.delete();
    exp_seq = 0; half = 1'b0; exp_uf = 1'b0;

    // 32-bit lanes, fixed pattern, across one full sequence period.
    set_width(32);
    reset_dut();
    for (int i = 0; i < 17; i++) send_block(2'b01, 64'hA5A5A5A5_5A5A5A5A, 1'b1);
    check_out();

    // 64-bit lanes, alternating headers and incrementing payloads.
    set_width(64);
    reset_dut();
    for (int i = 0; i < 64; i++)
      send_block((i % 2 == 0) ? 2'b01 : 2'b10,
                 {32'(i) + 32'h100, 32'hC0DE0000 + 32'($urandom_range(0, 65535))}, 1'b1);
    check_out();

    // Underflow at seq 5 on the 64-bit lane; later blocks must stay aligned.
    reset_dut();
    for (int i = 0; i < 20; i++)
      send_block(2'b10, {32'h5EED0000 + 32'(i), 32'($urandom)}, (i != 5));
    for (int i = 0; i < 40; i++) begin
      if (exp_seq == 17) break;
      send_block(2'b01, {32'($urandom), 32'($urandom)}, 1'b1);
    end
    check_out();

    // Asynchronous reset mid-stream at seq 17.
    rst_n = 1'b0;
    #1;
    sample(od, op, os, ou);
    check("async_data", od, 64'h0);
    check("async_seq", 64'(os), 64'h0);
    check("async_uf", 64'(ou), 64'h0);
    check("async_pause", 64'(op), 64'h0);
    @(negedge clk);
    reset_dut();
    send_block(2'b10, 64'h1111_2222_3333_4444, 1'b1);
    sample(od, op, os, ou);
    check("hdr_after_rst", 64'(od[1:0]), 64'h2);
    for (int i = 0; i < 4; i++) send_block(2'b01, {32'($urandom), 32'($urandom)}, 1'b1);
    check_out();

    // Bypass on the 32-bit lane, then back to gearbox mode.
    set_width(32);
    reset_dut();
    for (int k = 1; k <= 3; k++) begin
      drive_in(64'(k), 2'b00, 1'b1, 1'b1);
      @(negedge clk);
      sample(od, op, os, ou);
      check("byp_data", od, 64'(k));
      check("byp_pause", 64'(op), 64'h0);
      check("byp_seq", 64'(os), 64'h0);
    end
    for (int i = 0; i < 3; i++) send_block(2'b01, {32'($urandom), 32'($urandom)}, 1'b1);
    check_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
